truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter EXPECTED, default 8'hE2, golden truth table; bit i = expected F for input vector i, where i = {A,B,C} and A is the MSB.
REQ-002 Parameter SETTLE, default 2, range 0..15, extra hold cycles per vector before F is sampled.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  sweep request, level-sampled.
REQ-006 abort  in  1  synchronous cancel of a running sweep.
REQ-007 A, B, C  out  1 each  registered stimulus driven into the combinational datapath under test.
REQ-008 F  in  1  datapath response.
REQ-009 busy  out  1  high while a sweep is in progress.
REQ-010 done  out  1  one-cycle pulse when a sweep completes.
REQ-011 pass  out  1  high when the last completed sweep had zero mismatches.
REQ-012 fail_mask  out  8  bit i set when vector i mismatched.
REQ-013 fail_count  out  4  number of mismatching vectors, 0..8.
REQ-014 first_fail_idx  out  3  lowest mismatching vector index; 0 when there are none.

Function
REQ-015 FSM states: IDLE, HOLD, FINISH.
REQ-016 IDLE: if start=1 at an edge, go to HOLD, set idx=0, {A,B,C}=000, hold counter=SETTLE, busy=1, clear the scratch mask.
REQ-017 HOLD: each vector is held for SETTLE+1 cycles; the counter decrements each edge while nonzero.
REQ-018 HOLD: at the edge where the counter is 0, sample F and set scratch bit idx to (F != EXPECTED[idx]).
REQ-019 HOLD at that same edge, idx<7: increment idx, drive the new idx onto {A,B,C}, reload the counter with SETTLE.
REQ-020 HOLD at that same edge, idx=7: go to FINISH.
REQ-021 Sample timing: with start accepted at edge t0, vector i is sampled at edge t0+(i+1)*(SETTLE+1).
REQ-022 FINISH (one cycle, entered after the last sample): at its exit edge, fail_mask=scratch, fail_count=popcount(scratch), pass=(scratch==0), first_fail_idx=lowest set bit, done=1, busy=0, {A,B,C}=000, return to IDLE.
REQ-023 done is high for exactly one cycle (the first IDLE cycle after FINISH).
REQ-024 With SETTLE=2, done rises after edge t0+25.
REQ-025 Result outputs hold their values until the next sweep completes, or until abort or reset.
REQ-026 start is ignored while busy=1.
REQ-027 start asserted during the done cycle is accepted; a new sweep begins.
REQ-028 abort=1 while busy: at the next edge go to IDLE, busy=0, {A,B,C}=000, no done pulse, pass=0, fail_mask=0, fail_count=0, first_fail_idx=0.
REQ-029 abort has priority over start and over a pending sample.
REQ-030 abort in IDLE has no effect.
REQ-031 idx never exceeds 7; no wrap-around to vector 0 within a single sweep.

Reset
REQ-032 While rst=1, independent of clk: state=IDLE, A=B=C=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0, first_fail_idx=0, counter=0, idx=0.
REQ-033 rst asserted mid-sweep discards the partial result; after rst deasserts, the block waits in IDLE for start.

Verification
REQ-034 Golden model: F = EXPECTED[{A,B,C}], SETTLE=2, start pulse at t0 -> vectors 000..111 each held 3 cycles; done at t0+25; pass=1, fail_mask=00, fail_count=0.
REQ-035 Stuck-at-1 model: F=1, EXPECTED=E2 -> fail_mask=8'h1D, fail_count=4, first_fail_idx=0, pass=0.
REQ-036 Single-fault model: golden except F=1 at vector 011 -> fail_mask=8'h08, fail_count=1, first_fail_idx=3, pass=0.
REQ-037 Ignored start and abort: start re-pulsed at t0+5 -> no restart, done still at t0+25; a separate sweep with abort at t0+10 -> busy low at t0+11, no done pulse, all result outputs 0.
REQ-038 Async reset: rst raised mid-cycle at t0+7 -> all outputs 0 before the next clk edge; a later start gives a full correct sweep.
REQ-039 SETTLE=0 with the golden model -> one vector per cycle, done at t0+9, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight {A,B,C} vectors through an external combinational block and grades F against a golden table.
// Latency: (SETTLE+1) cycles per vector, 8*(SETTLE+1)+1 cycles from accepted start to the done pulse.
// No backpressure: start is ignored while busy, and abort cancels a running sweep at the next edge.
module truth_table_sweeper #(
  parameter logic [7:0]  EXPECTED = 8'hE2,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] abc, abc_nxt;
  logic [7:0] scratch, scratch_nxt;
  logic       busy_nxt, done_nxt, pass_nxt;
  logic [7:0] fail_mask_nxt;
  logic [3:0] fail_count_nxt;
  logic [2:0] first_fail_nxt;

  assign {A, B, C} = abc;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Scanning from the top down leaves the lowest set bit; an empty mask yields 0.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Next-state and next-output logic; every register holds unless a case below changes it.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    abc_nxt        = abc;
    scratch_nxt    = scratch;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    fail_mask_nxt  = fail_mask;
    fail_count_nxt = fail_count;
    first_fail_nxt = first_fail_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = HOLD;
          idx_nxt     = '0;
          abc_nxt     = '0;
          cnt_nxt     = SETTLE_V;
          busy_nxt    = 1'b1;
          scratch_nxt = '0;
        end
      end
      HOLD, FINISH: begin
        if (abort) begin
          // Cancel wins over everything, including a sample due on this edge.
          state_nxt      = IDLE;
          idx_nxt        = '0;
          cnt_nxt        = '0;
          abc_nxt        = '0;
          busy_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          fail_mask_nxt  = '0;
          fail_count_nxt = '0;
          first_fail_nxt = '0;
        end else if (state == FINISH) begin
          state_nxt      = IDLE;
          abc_nxt        = '0;
          busy_nxt       = 1'b0;
          done_nxt       = 1'b1;
          fail_mask_nxt  = scratch;
          fail_count_nxt = popcount8(scratch);
          pass_nxt       = (scratch == 8'h00);
          first_fail_nxt = lowest_set(scratch);
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          scratch_nxt[idx] = (F != EXPECTED[idx]);
          if (idx == 3'd7) begin
            state_nxt = FINISH;
          end else begin
            idx_nxt = idx + 3'd1;
            abc_nxt = idx + 3'd1;
            cnt_nxt = SETTLE_V;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      abc            <= '0;
      scratch        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      abc            <= abc_nxt;
      scratch        <= scratch_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_mask      <= fail_mask_nxt;
      fail_count     <= fail_count_nxt;
      first_fail_idx <= first_fail_nxt;
    end
  end

endmodule
